// File: rtl/ddr3_req_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 x16 local interface, including controller bring-up.
// Define DDR3_ARB_ERRCNT_EN to add the stray-read-beat counter outputs err_cnt / err_flag.
module ddr3_req_arbiter #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 64,
  parameter int BURST_W    = 5,
  parameter int INIT_DELAY = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                r0_req,
  input  logic                r0_we,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [BURST_W-1:0]  r0_burst,
  output logic                r0_gnt,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_wmask,
  output logic                r0_wrdy,
  output logic [DATA_W-1:0]   r0_rdata,
  output logic                r0_rvalid,
  input  logic                r1_req,
  input  logic                r1_we,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [BURST_W-1:0]  r1_burst,
  output logic                r1_gnt,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_wmask,
  output logic                r1_wrdy,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                r1_rvalid,
  output logic                mem_init_start,
  input  logic                mem_init_done,
  output logic [3:0]          mem_cmd,
  output logic                mem_cmd_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BURST_W-1:0]  mem_burst,
  input  logic                mem_cmd_rdy,
  input  logic                mem_datain_rdy,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_dmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
`ifdef DDR3_ARB_ERRCNT_EN
  output logic [7:0]          err_cnt,
  output logic                err_flag,
`endif
  output logic                ready
);

  localparam int PTR_W = (TAG_DEPTH < 2) ? 1 : $clog2(TAG_DEPTH);
  localparam int DLY_W = (INIT_DELAY < 2) ? 1 : $clog2(INIT_DELAY);
  localparam logic [3:0] CMD_RD = 4'b0001;
  localparam logic [3:0] CMD_WR = 4'b0010;

  typedef enum logic [2:0] {S_WAIT, S_INIT, S_IDLE, S_CMD, S_WDATA} state_t;
  state_t state_q, state_d;

  logic [DLY_W-1:0]   dly_cnt;
  logic               owner, rr_ptr;
  logic [BURST_W:0]   wbeat;
  logic               elig0, elig1, any_elig, win;
  logic               cmd_acc, wbeat_take, push, pop, rbeat, rd_last;

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     fcnt;
  logic [BURST_W:0]   rd_cnt;
  logic [TAG_DEPTH-1:0] tag_own;
  logic [BURST_W-1:0] tag_burst [TAG_DEPTH];
  logic               fifo_full, fifo_empty, head_own;
  logic [BURST_W:0]   head_len;

  assign fifo_full  = (fcnt == (PTR_W+1)'(TAG_DEPTH));
  assign fifo_empty = (fcnt == '0);
  assign head_own   = tag_own[rd_ptr];
  assign head_len   = {tag_burst[rd_ptr] == '0, tag_burst[rd_ptr]};

  // Reads need a free tag slot; writes never touch the tag FIFO.
  assign elig0    = r0_req && (r0_we || !fifo_full);
  assign elig1    = r1_req && (r1_we || !fifo_full);
  assign any_elig = elig0 || elig1;
  // rr_ptr names the port favoured on a tie, i.e. the one that did not win last.
  assign win      = (elig0 && elig1) ? rr_ptr : elig1;

  assign cmd_acc    = (state_q == S_CMD) && mem_cmd_rdy;
  assign wbeat_take = (state_q == S_WDATA) && mem_datain_rdy;
  assign push       = cmd_acc && (mem_cmd == CMD_RD);
  assign rbeat      = mem_rvalid && !fifo_empty;
  assign rd_last    = ((rd_cnt + 1'b1) == head_len);
  assign pop        = rbeat && rd_last;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    r0_gnt    = cmd_acc && !owner;
    r1_gnt    = cmd_acc && owner;
    r0_wrdy   = wbeat_take && !owner;
    r1_wrdy   = wbeat_take && owner;
    mem_wdata = '0;
    mem_dmask = '0;
    case (state_q)
      S_WAIT:  if (dly_cnt == DLY_W'(INIT_DELAY - 1)) state_d = S_INIT;
      S_INIT:  if (mem_init_done) state_d = S_IDLE;
      S_IDLE:  if (any_elig) state_d = S_CMD;
      S_CMD:   if (mem_cmd_rdy) state_d = (mem_cmd == CMD_WR) ? S_WDATA : S_IDLE;
      S_WDATA: begin
        mem_wdata = owner ? r1_wdata : r0_wdata;
        mem_dmask = owner ? r1_wmask : r0_wmask;
        if (mem_datain_rdy && wbeat == 1) state_d = S_IDLE;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dly_cnt        <= '0;
      mem_init_start <= 1'b0;
      ready          <= 1'b0;
      mem_cmd_valid  <= 1'b0;
      mem_cmd        <= '0;
      mem_addr       <= '0;
      mem_burst      <= '0;
      owner          <= 1'b0;
      rr_ptr         <= 1'b0;
      wbeat          <= '0;
    end else begin
      if (state_q == S_WAIT) begin
        dly_cnt <= dly_cnt + 1'b1;
        if (dly_cnt == DLY_W'(INIT_DELAY - 1)) mem_init_start <= 1'b1;
      end
      if (state_q == S_INIT && mem_init_done) begin
        mem_init_start <= 1'b0;
        ready          <= 1'b1;
      end
      if (state_q == S_IDLE && any_elig) begin
        owner         <= win;
        mem_cmd       <= (win ? r1_we : r0_we) ? CMD_WR : CMD_RD;
        mem_addr      <= win ? r1_addr : r0_addr;
        mem_burst     <= win ? r1_burst : r0_burst;
        mem_cmd_valid <= 1'b1;
      end
      if (cmd_acc) begin
        mem_cmd_valid <= 1'b0;
        rr_ptr        <= ~owner;
        wbeat         <= {mem_burst == '0, mem_burst};
      end
      if (wbeat_take) wbeat <= wbeat - 1'b1;
    end
  end

  // In-order read tags: the head entry owns every returning beat until its burst completes.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_own[wr_ptr]   <= owner;
      tag_burst[wr_ptr] <= mem_burst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fcnt      <= '0;
      rd_cnt    <= '0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rdata  <= mem_rdata;
      r1_rdata  <= mem_rdata;
      r0_rvalid <= rbeat && !head_own;
      r1_rvalid <= rbeat && head_own;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rbeat) begin
        if (rd_last) begin
          rd_cnt <= '0;
          rd_ptr <= rd_ptr + 1'b1;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

`ifdef DDR3_ARB_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (mem_rvalid && fifo_empty) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      err_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed bench for ddr3_req_arbiter: bring-up, arbitration, write data, tag FIFO and stray beats.
module tb_ddr3_req_arbiter;
  localparam int AW = 26, DW = 64, BW = 5, MW = DW/8;
  localparam logic [3:0] RD = 4'b0001;

  logic clk = 1'b0, rstn;
  logic r0_req, r0_we, r0_gnt, r0_wrdy, r0_rvalid;
  logic r1_req, r1_we, r1_gnt, r1_wrdy, r1_rvalid;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr;
  logic [BW-1:0] r0_burst, r1_burst, mem_burst;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [MW-1:0] r0_wmask, r1_wmask, mem_dmask;
  logic mem_init_start, mem_init_done, mem_cmd_valid, mem_cmd_rdy;
  logic mem_datain_rdy, mem_rvalid, ready;
  logic [3:0] mem_cmd;
`ifdef DDR3_ARB_ERRCNT_EN
  logic [7:0] err_cnt;
  logic err_flag;
`endif

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ddr3_req_arbiter dut (
    .clk(clk), .rstn(rstn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_burst(r0_burst), .r0_gnt(r0_gnt),
    .r0_wdata(r0_wdata), .r0_wmask(r0_wmask), .r0_wrdy(r0_wrdy), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_burst(r1_burst), .r1_gnt(r1_gnt),
    .r1_wdata(r1_wdata), .r1_wmask(r1_wmask), .r1_wrdy(r1_wrdy), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .mem_init_start(mem_init_start), .mem_init_done(mem_init_done),
    .mem_cmd(mem_cmd), .mem_cmd_valid(mem_cmd_valid), .mem_addr(mem_addr), .mem_burst(mem_burst),
    .mem_cmd_rdy(mem_cmd_rdy), .mem_datain_rdy(mem_datain_rdy), .mem_wdata(mem_wdata), .mem_dmask(mem_dmask),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
`ifdef DDR3_ARB_ERRCNT_EN
    .err_cnt(err_cnt), .err_flag(err_flag),
`endif
    .ready(ready)
  );

  // Waits (bounded) for a grant on one port; reports whether the other port was granted meanwhile.
  task automatic wait_gnt(input int port, output int cyc, output bit other);
    cyc = -1; other = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port == 0 ? r1_gnt : r0_gnt) other = 1'b1;
      if (port == 0 ? r0_gnt : r1_gnt) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset;
    bit leak;
    rstn = 1'b0;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_burst = '0; r0_wdata = '0; r0_wmask = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_burst = '0; r1_wdata = '0; r1_wmask = '0;
    mem_init_done = 0; mem_cmd_rdy = 1; mem_datain_rdy = 0; mem_rdata = '0; mem_rvalid = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_init_start, ready, mem_cmd_valid, r0_rvalid, r1_rvalid, r0_gnt, r1_gnt} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs got init=%b rdy=%b vld=%b", mem_init_start, ready, mem_cmd_valid);
    end
`ifdef DDR3_ARB_ERRCNT_EN
    total++;
    if (err_cnt !== 8'd0 || err_flag !== 1'b0) begin
      bad++; $display("FAIL reset_err got cnt=%0d flag=%b want 0/0", err_cnt, err_flag);
    end
`endif
    rstn = 1'b1;
    r0_req = 1; r0_we = 0; r0_burst = 5'd1;
    leak = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (mem_cmd_valid || r0_gnt) leak = 1'b1;
    end
    total++;
    if (mem_init_start !== 1'b0) begin bad++; $display("FAIL init_early got %b want 0 after 15 clk", mem_init_start); end
    @(negedge clk);
    total++;
    if (mem_init_start !== 1'b1) begin bad++; $display("FAIL init_start got %b want 1 after 16 clk", mem_init_start); end
    repeat (5) begin
      @(negedge clk);
      if (mem_cmd_valid || r0_gnt) leak = 1'b1;
    end
    total++;
    if (mem_init_start !== 1'b1 || ready !== 1'b0) begin
      bad++; $display("FAIL init_hold got init=%b rdy=%b want 1/0", mem_init_start, ready);
    end
    total++;
    if (leak) begin bad++; $display("FAIL pre_ready_req got grant/valid want none"); end
    mem_init_done = 1; r0_req = 0;
    @(negedge clk);
    mem_init_done = 0;
    total++;
    if (mem_init_start !== 1'b0 || ready !== 1'b1) begin
      bad++; $display("FAIL init_done got init=%b rdy=%b want 0/1", mem_init_start, ready);
    end
    repeat (3) @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL ready_sticky got %b want 1", ready); end
  endtask

  task automatic test_two_reads;
    int cyc; bit other, both;
    r0_req = 1; r0_we = 0; r0_addr = 26'h0100; r0_burst = 5'd8;
    r1_req = 1; r1_we = 0; r1_addr = 26'h0200; r1_burst = 5'd8;
    wait_gnt(0, cyc, other);
    total++;
    if (cyc < 0 || other) begin bad++; $display("FAIL tie_r0_first got cyc=%0d other=%b want r0 grant first", cyc, other); end
    total++;
    if (mem_addr !== 26'h0100 || mem_cmd !== RD || mem_burst !== 5'd8) begin
      bad++; $display("FAIL r0_cmd got addr=%h cmd=%b want 0100/0001", mem_addr, mem_cmd);
    end
    r0_req = 0;
    wait_gnt(1, cyc, other);
    total++;
    if (cyc < 0 || other) begin bad++; $display("FAIL r1_second got cyc=%0d other=%b", cyc, other); end
    total++;
    if (mem_addr !== 26'h0200) begin bad++; $display("FAIL r1_addr got %h want 0200", mem_addr); end
    r1_req = 0;
    both = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) begin
        if (r0_rvalid && r1_rvalid) both = 1'b1;
        total++;
        if (j <= 8) begin
          if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_rdata !== 64'hD000 + 64'(j-1)) begin
            bad++; $display("FAIL rd_r0_beat%0d got v0=%b v1=%b d=%h", j-1, r0_rvalid, r1_rvalid, r0_rdata);
          end
        end else begin
          if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== 64'hD000 + 64'(j-1)) begin
            bad++; $display("FAIL rd_r1_beat%0d got v0=%b v1=%b d=%h", j-1, r0_rvalid, r1_rvalid, r1_rdata);
          end
        end
      end
      mem_rvalid = (j < 16);
      mem_rdata  = 64'hD000 + 64'(j);
      @(negedge clk);
    end
    total++;
    if (both || r0_rvalid || r1_rvalid) begin bad++; $display("FAIL rd_tail got both=%b v0=%b v1=%b want 0", both, r0_rvalid, r1_rvalid); end
  endtask

  task automatic test_write;
    int cyc, pulses; bit other, r0_bad, data_bad;
    r1_req = 1; r1_we = 1; r1_addr = 26'h0300; r1_burst = 5'd4;
    wait_gnt(1, cyc, other);
    total++;
    if (cyc < 0) begin bad++; $display("FAIL wr_gnt got timeout want grant"); end
    r1_req = 0;
    @(negedge clk);
    pulses = 0; r0_bad = 0; data_bad = 0;
    for (int i = 0; i < 12; i++) begin
      mem_datain_rdy = (i % 2 == 0);
      r1_wdata = 64'hB000 + 64'(i); r1_wmask = 8'(i + 1);
      r0_wdata = 64'hFFFF_0000 + 64'(i); r0_wmask = 8'hFF;
      #1;
      if (r0_wrdy) r0_bad = 1;
      if (r1_wrdy) begin
        pulses++;
        if (mem_wdata !== r1_wdata || mem_dmask !== r1_wmask) data_bad = 1;
      end
      @(negedge clk);
    end
    mem_datain_rdy = 0;
    total++;
    if (pulses !== 4) begin bad++; $display("FAIL wr_pulses got %0d want 4", pulses); end
    total++;
    if (data_bad) begin bad++; $display("FAIL wr_data got wrong mem_wdata/dmask want r1 beat"); end
    total++;
    if (r0_bad) begin bad++; $display("FAIL wr_r0_wrdy got 1 want 0"); end
  endtask

  task automatic test_fifo_full;
    int cyc; bit other, stuck;
    for (int k = 0; k < 4; k++) begin
      r0_req = 1; r0_we = 0; r0_addr = 26'(16'h0400 + k); r0_burst = 5'd1;
      wait_gnt(0, cyc, other);
      total++;
      if (cyc < 0) begin bad++; $display("FAIL fill_rd%0d got timeout want grant", k); end
    end
    r0_req = 1; r0_addr = 26'h0500;
    r1_req = 1; r1_we = 1; r1_addr = 26'h0600; r1_burst = 5'd1;
    wait_gnt(1, cyc, other);
    total++;
    if (cyc < 0 || other) begin bad++; $display("FAIL full_r1_write got cyc=%0d r0gnt=%b want r1 only", cyc, other); end
    r1_req = 0; mem_datain_rdy = 1;
    repeat (2) @(negedge clk);
    mem_datain_rdy = 0;
    stuck = 0;
    repeat (5) begin
      @(negedge clk);
      if (r0_gnt || mem_cmd_valid) stuck = 1;
    end
    total++;
    if (stuck) begin bad++; $display("FAIL full_r0_wait got grant want wait"); end
    mem_rvalid = 1; mem_rdata = 64'hE0;
    @(negedge clk);
    mem_rvalid = 0;
    total++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 64'hE0) begin bad++; $display("FAIL full_pop got v=%b d=%h", r0_rvalid, r0_rdata); end
    wait_gnt(0, cyc, other);
    total++;
    if (cyc !== 0) begin bad++; $display("FAIL after_pop_gnt got cyc=%0d want 0", cyc); end
    r0_req = 0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1; mem_rdata = 64'hE1 + 64'(k);
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin bad++; $display("FAIL drain%0d got v0=%b v1=%b", k, r0_rvalid, r1_rvalid); end
    end
    mem_rvalid = 0;
    @(negedge clk);
  endtask

  task automatic test_cmd_stall;
    int gcnt; bit unstable;
    mem_cmd_rdy = 0;
    r0_req = 1; r0_we = 0; r0_addr = 26'h0ABC; r0_burst = 5'd2;
    gcnt = 0; unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_cmd_valid !== 1'b1 || mem_addr !== 26'h0ABC || mem_cmd !== RD || mem_burst !== 5'd2) unstable = 1;
      if (r0_gnt) gcnt++;
    end
    total++;
    if (unstable || gcnt != 0) begin bad++; $display("FAIL stall_hold got unstable=%b gnt=%0d", unstable, gcnt); end
    mem_cmd_rdy = 1;
    #1;
    total++;
    if (r0_gnt !== 1'b1) begin bad++; $display("FAIL stall_release got gnt=%b want 1", r0_gnt); end
    r0_req = 0;
    @(negedge clk);
    total++;
    if (r0_gnt !== 1'b0 || mem_cmd_valid !== 1'b0) begin bad++; $display("FAIL stall_after got gnt=%b vld=%b want 0/0", r0_gnt, mem_cmd_valid); end
    mem_rvalid = 1;
    repeat (2) @(negedge clk);
    mem_rvalid = 0;
    @(negedge clk);
  endtask

  task automatic test_stray;
    bit seen;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1; mem_rdata = 64'h5A;
      @(negedge clk);
      if (r0_rvalid || r1_rvalid) seen = 1;
    end
    mem_rvalid = 0;
    @(negedge clk);
    if (r0_rvalid || r1_rvalid) seen = 1;
    total++;
    if (seen) begin bad++; $display("FAIL stray_rvalid got rvalid want none"); end
`ifdef DDR3_ARB_ERRCNT_EN
    total++;
    if (err_cnt !== 8'd3 || err_flag !== 1'b1) begin bad++; $display("FAIL stray_err got cnt=%0d flag=%b want 3/1", err_cnt, err_flag); end
`endif
  endtask

  task automatic test_mid_reset;
    r1_req = 1; r1_we = 1; r1_addr = 26'h0777; r1_burst = 5'd3;
    mem_cmd_rdy = 0;
    @(negedge clk);
    total++;
    if (mem_cmd_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got vld=%b want 1", mem_cmd_valid); end
    rstn = 0;
    @(negedge clk);
    total++;
    if (mem_cmd_valid !== 1'b0 || ready !== 1'b0 || r1_gnt !== 1'b0 || mem_addr !== '0) begin
      bad++; $display("FAIL midrst got vld=%b rdy=%b gnt=%b addr=%h want 0", mem_cmd_valid, ready, r1_gnt, mem_addr);
    end
    r1_req = 0; mem_cmd_rdy = 1; rstn = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_two_reads;
    test_write;
    test_fifo_full;
    test_cmd_stall;
    test_stray;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
